edulent_core_p: RTL

- Parametrised next-generation edulent accumulator core: control FSM and datapath merged into one block, with generic data/address width.
- Memory sits outside the block behind a req/ack handshake, so wait-state memories are supported.
- Adds carry flag, stack, I/O strobes, single-step debug mode and halt.
- Instantiated by the SoC top next to the memory module.

---
 rtl/edulent_core_p_if.sv | 18 +
 rtl/edulent_core_p.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edulent_core_p_if.sv
// Memory request/acknowledge bus between the edulent core and its memory.
`timescale 1ns/1ps
interface edulent_core_p_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, output we, output addr, output wdata,
                   input  rdata, input  ack);
   modport slave  (input  req, input  we, input  addr, input  wdata,
                   output rdata, output ack);
endinterface

// File: rtl/edulent_core_p.sv
// Edulent accumulator core: control FSM plus datapath, external memory via req/ack.
`timescale 1ns/1ps
module edulent_core_p #(
   parameter int unsigned       DATA_W  = 8,
   parameter int unsigned       ADDR_W  = 8,
   parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [DATA_W-1:0]   i_in,
   output logic [DATA_W-1:0]   o_out,
   output logic                o_out_valid,
   edulent_core_p_if.master    mem,
   input  logic                i_step_mode,
   input  logic                i_step,
   output logic                o_halted,
   output logic [ADDR_W-1:0]   o_pc
);

   // Elaboration-time parameter sanity checks
   if (DATA_W < 8 || DATA_W > 32) begin : g_bad_data_w
      $error("edulent_core_p: DATA_W must be in 8..32");
   end
   if (ADDR_W > DATA_W) begin : g_bad_addr_w
      $error("edulent_core_p: ADDR_W must not exceed DATA_W");
   end

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_JC   = 4'hA;
   localparam logic [3:0] OP_IN   = 4'hB;
   localparam logic [3:0] OP_OUT  = 4'hC;
   localparam logic [3:0] OP_PUSH = 4'hD;
   localparam logic [3:0] OP_POP  = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   typedef enum logic [2:0] {
      S_STEPWAIT, S_FETCH, S_DECODE, S_OPERAND, S_MEM, S_EXEC, S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] sp_q, sp_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic              c_q, c_d;
   logic [3:0]        ir_q, ir_d;
   logic [DATA_W-1:0] opr_q, opr_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              halted_q, halted_d;

   logic [DATA_W:0]   sum_c;
   logic [DATA_W:0]   diff_c;
   logic [ADDR_W-1:0] sp_inc_c;
   logic              done_c;

   // ALU and helper terms; diff MSB is the borrow out of the subtraction
   assign sum_c    = {1'b0, a_q} + {1'b0, mdr_q};
   assign diff_c   = {1'b0, a_q} - {1'b0, mdr_q};
   assign sp_inc_c = sp_q + ADDR_W'(1);
   assign done_c   = req_q & mem.ack;

   // Next-state, datapath and bus request logic
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      sp_d        = sp_q;
      a_d         = a_q;
      c_d         = c_q;
      ir_d        = ir_q;
      opr_d       = opr_q;
      mdr_d       = mdr_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      halted_d    = halted_q;

      unique case (state_q)
         S_STEPWAIT: begin
            if (i_step) begin
               state_d = S_FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_q;
            end
         end
         S_FETCH: begin
            // Idle FETCH only occurs straight out of reset
            if (!req_q) begin
               if (i_step_mode) begin
                  state_d = S_STEPWAIT;
               end else begin
                  req_d  = 1'b1;
                  we_d   = 1'b0;
                  addr_d = pc_q;
               end
            end else if (mem.ack) begin
               req_d   = 1'b0;
               ir_d    = mem.rdata[DATA_W-1 -: 4];
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (ir_q >= OP_LDI && ir_q <= OP_JC) begin
               state_d = S_OPERAND;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_q;
            end else if (ir_q == OP_PUSH) begin
               state_d = S_MEM;
               req_d   = 1'b1;
               we_d    = 1'b1;
               addr_d  = sp_q;
               wdata_d = a_q;
            end else if (ir_q == OP_POP) begin
               state_d = S_MEM;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = sp_inc_c;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_OPERAND: begin
            if (done_c) begin
               req_d = 1'b0;
               opr_d = mem.rdata;
               pc_d  = pc_q + ADDR_W'(1);
               if (ir_q >= OP_LD && ir_q <= OP_OR) begin
                  state_d = S_MEM;
                  req_d   = 1'b1;
                  we_d    = (ir_q == OP_ST);
                  addr_d  = mem.rdata[ADDR_W-1:0];
                  wdata_d = a_q;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_MEM: begin
            if (done_c) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               mdr_d   = mem.rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            unique case (ir_q)
               OP_LDI:  a_d = opr_q;
               OP_LD:   a_d = mdr_q;
               OP_ADD:  {c_d, a_d} = sum_c;
               OP_SUB:  begin a_d = diff_c[DATA_W-1:0]; c_d = diff_c[DATA_W]; end
               OP_AND:  a_d = a_q & mdr_q;
               OP_OR:   a_d = a_q | mdr_q;
               OP_JMP:  pc_d = opr_q[ADDR_W-1:0];
               OP_JZ:   if (a_q == '0) pc_d = opr_q[ADDR_W-1:0];
               OP_JC:   if (c_q) pc_d = opr_q[ADDR_W-1:0];
               OP_IN:   a_d = i_in;
               OP_OUT:  begin out_d = a_q; out_valid_d = 1'b1; end
               OP_PUSH: sp_d = sp_q - ADDR_W'(1);
               OP_POP:  begin sp_d = sp_inc_c; a_d = mdr_q; end
               default: ;
            endcase
            if (ir_q == OP_HLT) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else if (i_step_mode) begin
               state_d = S_STEPWAIT;
            end else begin
               state_d = S_FETCH;
               req_d   = 1'b1;
               we_d    = 1'b0;
               addr_d  = pc_d;
            end
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_FETCH;
         pc_q        <= '0;
         sp_q        <= SP_INIT;
         a_q         <= '0;
         c_q         <= 1'b0;
         ir_q        <= '0;
         opr_q       <= '0;
         mdr_q       <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         sp_q        <= sp_d;
         a_q         <= a_d;
         c_q         <= c_d;
         ir_q        <= ir_d;
         opr_q       <= opr_d;
         mdr_q       <= mdr_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
      end
   end

   assign mem.req     = req_q;
   assign mem.we      = we_q;
   assign mem.addr    = addr_q;
   assign mem.wdata   = wdata_q;
   assign o_out       = out_q;
   assign o_out_valid = out_valid_q;
   assign o_halted    = halted_q;
   assign o_pc        = pc_q;

endmodule
